alu_share_arbiter: RTL and testbench

Two-port round-robin arbiter and sequencer that shares one combinational ALU between two requesters, e.g. the main execute path and an address/branch helper unit. It accepts one operation at a time through a valid/ready handshake and drives the ALU from registered operands. It captures the ALU result and zero flag and returns them to the winning requester through a valid/ready response channel. It sits beside the ALU in the execute stage and is the only block that drives the ALU's SrcA/SrcB/ALUControl inputs.

---
 rtl/alu_share_arbiter_if.sv | 29 ++
 rtl/alu_share_arbiter.sv | 100 ++++++++++
 tb/tb_alu_share_arbiter.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between the two ALU requesters and alu_share_arbiter.
// Handshake: a transfer happens on a rising edge where valid and ready are both high.
interface alu_share_arbiter_if #(
  parameter int DATA    = 32,
  parameter int CONTROL = 3
);
  logic               req0_valid, req1_valid;
  logic               req0_ready, req1_ready;
  logic [DATA-1:0]    req0_a, req0_b, req1_a, req1_b;
  logic [CONTROL-1:0] req0_op, req1_op;
  logic               resp0_valid, resp1_valid;
  logic               resp0_ready, resp1_ready;
  logic [DATA-1:0]    resp0_result, resp1_result;
  logic               resp0_zero, resp1_zero;

  modport master (
    output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, req0_op, req1_op,
    output resp0_ready, resp1_ready,
    input  req0_ready, req1_ready,
    input  resp0_valid, resp1_valid, resp0_result, resp1_result, resp0_zero, resp1_zero
  );

  modport slave (
    input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, req0_op, req1_op,
    input  resp0_ready, resp1_ready,
    output req0_ready, req1_ready,
    output resp0_valid, resp1_valid, resp0_result, resp1_result, resp0_zero, resp1_zero
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sequencer sharing one combinational ALU between two requesters:
// accept one op, drive the ALU from registered operands, return the captured result.
module alu_share_arbiter #(
  parameter int DATA    = 32,
  parameter int CONTROL = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_share_arbiter_if.slave bus,
  output logic [DATA-1:0]    alu_srca,
  output logic [DATA-1:0]    alu_srcb,
  output logic [CONTROL-1:0] alu_ctrl,
  input  logic [DATA-1:0]    alu_result,
  input  logic               alu_zero,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state;
  logic            last_grant;
  logic            owner;
  logic [DATA-1:0] result_q;
  logic            zero_q;
  logic            resp0_valid_q, resp1_valid_q;

  logic winner;
  logic accept;
  logic resp_take;

  // On a tie the requester that did not win last time goes first.
  always_comb begin
    winner = 1'b0;
    if (bus.req0_valid && bus.req1_valid) winner = ~last_grant;
    else if (bus.req1_valid)              winner = 1'b1;
  end

  // Ready is held low while reset is asserted so no requester sees a phantom accept.
  assign bus.req0_ready = rst_n && (state == IDLE) && bus.req0_valid && !winner;
  assign bus.req1_ready = rst_n && (state == IDLE) && bus.req1_valid &&  winner;
  assign accept         = bus.req0_ready || bus.req1_ready;
  assign resp_take      = owner ? bus.resp1_ready : bus.resp0_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      last_grant    <= 1'b1;
      owner         <= 1'b0;
      alu_srca      <= '0;
      alu_srcb      <= '0;
      alu_ctrl      <= '0;
      result_q      <= '0;
      zero_q        <= 1'b0;
      resp0_valid_q <= 1'b0;
      resp1_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            alu_srca   <= winner ? bus.req1_a  : bus.req0_a;
            alu_srcb   <= winner ? bus.req1_b  : bus.req0_b;
            alu_ctrl   <= winner ? bus.req1_op : bus.req0_op;
            owner      <= winner;
            last_grant <= winner;
            state      <= EXEC;
          end
        end
        EXEC: begin
          result_q      <= alu_result;
          zero_q        <= alu_zero;
          resp0_valid_q <= ~owner;
          resp1_valid_q <= owner;
          state         <= RESP;
        end
        RESP: begin
          if (resp_take) begin
            resp0_valid_q <= 1'b0;
            resp1_valid_q <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Result and zero are shared; only the owner's valid qualifies them.
  assign bus.resp0_valid  = resp0_valid_q;
  assign bus.resp1_valid  = resp1_valid_q;
  assign bus.resp0_result = result_q;
  assign bus.resp1_result = result_q;
  assign bus.resp0_zero   = zero_q;
  assign bus.resp1_zero   = zero_q;
  assign dbg_state        = state;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed scenarios plus random two-port traffic,
// checked every cycle against a transaction-level model with literal result pins.
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] alu_srca, alu_srcb, alu_result;
  logic [2:0]  alu_ctrl;
  logic        alu_zero;
  logic [1:0]  dbg_state;

  alu_share_arbiter_if #(.DATA(32), .CONTROL(3)) bus ();

  alu_share_arbiter #(.DATA(32), .CONTROL(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .alu_srca   (alu_srca),
    .alu_srcb   (alu_srcb),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .dbg_state  (dbg_state)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_fn(input logic [31:0] a, b, input logic [2:0] op);
    case (op)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b101:  return {31'b0, a < b};
      default: return 32'h0;
    endcase
  endfunction

  // The ALU beside the arbiter.
  always_comb begin
    alu_result = alu_fn(alu_srca, alu_srcb, alu_ctrl);
    alu_zero   = ((alu_srca - alu_srcb) == 32'h0);
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Literal expectations: {zero, result} per completed op, and grant order.
  logic [32:0] exp_q[$];
  logic [0:0]  gnt_q[$];

  // Transaction-level model.
  bit          m_busy  = 0;
  bit          m_rdy   = 0;  // result already captured, response offered
  bit          m_owner = 0;
  bit          m_last  = 1;
  logic [31:0] m_a = 0, m_b = 0, m_res = 0, m_pres = 0;
  logic [2:0]  m_op = 0;
  bit          m_zero = 0, m_pzero = 0;
  bit          chk_on = 0;

  always @(negedge clk) begin
    if (chk_on) begin
      bit w, e_r0, e_r1;
      logic [32:0] lit;
      logic [0:0]  g;
      w    = (bus.req0_valid && bus.req1_valid) ? !m_last : bus.req1_valid;
      e_r0 = rst_n && !m_busy && bus.req0_valid && !w;
      e_r1 = rst_n && !m_busy && bus.req1_valid &&  w;
      chk("req0_ready",   {32'b0, bus.req0_ready},  {32'b0, e_r0});
      chk("req1_ready",   {32'b0, bus.req1_ready},  {32'b0, e_r1});
      chk("alu_srca",     {1'b0, alu_srca},         {1'b0, m_a});
      chk("alu_srcb",     {1'b0, alu_srcb},         {1'b0, m_b});
      chk("alu_ctrl",     {30'b0, alu_ctrl},        {30'b0, m_op});
      chk("resp0_valid",  {32'b0, bus.resp0_valid}, {32'b0, m_rdy && !m_owner});
      chk("resp1_valid",  {32'b0, bus.resp1_valid}, {32'b0, m_rdy &&  m_owner});
      chk("resp0_result", {1'b0, bus.resp0_result}, {1'b0, m_res});
      chk("resp1_result", {1'b0, bus.resp1_result}, {1'b0, m_res});
      chk("resp0_zero",   {32'b0, bus.resp0_zero},  {32'b0, m_zero});
      chk("resp1_zero",   {32'b0, bus.resp1_zero},  {32'b0, m_zero});

      // Advance the model to what the coming rising edge produces.
      if (!rst_n) begin
        m_busy = 0; m_rdy = 0; m_owner = 0; m_last = 1;
        m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_zero = 0;
      end else if (!m_busy) begin
        if (bus.req0_valid || bus.req1_valid) begin
          if (gnt_q.size() != 0) begin
            g = gnt_q.pop_front();
            chk("grant_order", {32'b0, bus.req1_ready && !bus.req0_ready}, {32'b0, g});
          end
          m_busy  = 1;
          m_owner = w;
          m_last  = w;
          m_a     = w ? bus.req1_a  : bus.req0_a;
          m_b     = w ? bus.req1_b  : bus.req0_b;
          m_op    = w ? bus.req1_op : bus.req0_op;
          m_pres  = alu_fn(m_a, m_b, m_op);
          m_pzero = (m_a == m_b);
        end
      end else if (!m_rdy) begin
        m_rdy  = 1;
        m_res  = m_pres;
        m_zero = m_pzero;
      end else if (m_owner ? bus.resp1_ready : bus.resp0_ready) begin
        if (exp_q.size() != 0) begin
          lit = exp_q.pop_front();
          if (m_owner) chk("resp1_literal", {bus.resp1_zero, bus.resp1_result}, lit);
          else         chk("resp0_literal", {bus.resp0_zero, bus.resp0_result}, lit);
        end
        m_busy = 0;
        m_rdy  = 0;
      end
    end
  end

  // Driver: present an op on port p and hold it until accepted.
  task automatic do_op(input int p, input logic [31:0] a, b, input logic [2:0] op);
    bit got = 0;
    if (p == 0) begin
      bus.req0_valid = 1; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
    end else begin
      bus.req1_valid = 1; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
    end
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      got = (p == 0) ? bus.req0_ready : bus.req1_ready;
    end
    @(posedge clk); #1;
    if (p == 0) bus.req0_valid = 0; else bus.req1_valid = 0;
    if (!got) begin
      tests++; fails++;
      $display("FAIL accept_timeout: port %0d got no ready expected ready within 200 cycles", p);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  bit d0, d1;

  initial begin
    bus.req0_valid = 0; bus.req1_valid = 0;
    bus.req0_a = 0; bus.req0_b = 0; bus.req0_op = 0;
    bus.req1_a = 0; bus.req1_b = 0; bus.req1_op = 0;
    bus.resp0_ready = 1; bus.resp1_ready = 1;
    @(posedge clk); #1;
    chk_on = 1;
    cycles(1);
    rst_n = 1;

    // Single op, then the op-code corner cases.
    exp_q.push_back({1'b0, 32'd12});
    do_op(0, 32'd5, 32'd7, 3'b000);
    cycles(4);
    exp_q.push_back({1'b1, 32'd0});
    do_op(1, 32'd9, 32'd9, 3'b001);
    cycles(4);
    exp_q.push_back({1'b0, 32'd1});
    do_op(0, 32'd3, 32'd5, 3'b101);
    cycles(4);
    exp_q.push_back({1'b0, 32'd0});
    do_op(1, 32'hFFFF_FFFF, 32'd1, 3'b101);
    cycles(4);
    exp_q.push_back({1'b0, 32'd0});
    do_op(0, 32'd6, 32'd2, 3'b100);
    cycles(4);

    // Round-robin from reset: both ports always valid.
    rst_n = 0; cycles(1); rst_n = 1;
    gnt_q = '{1'b0, 1'b1, 1'b0, 1'b1};
    exp_q.push_back({1'b0, 32'd3}); exp_q.push_back({1'b0, 32'd30});
    exp_q.push_back({1'b0, 32'd7}); exp_q.push_back({1'b0, 32'd70});
    fork
      begin do_op(0, 32'd1, 32'd2, 3'b000); do_op(0, 32'd3, 32'd4, 3'b000); end
      begin do_op(1, 32'd10, 32'd20, 3'b000); do_op(1, 32'd30, 32'd40, 3'b000); end
    join
    cycles(4);

    // Backpressure on port 0 while port 1 waits.
    bus.resp0_ready = 0;
    exp_q.push_back({1'b0, 32'hFFFF_FFFE});
    exp_q.push_back({1'b0, 32'h0000_0044});
    do_op(0, 32'd20, 32'd22, 3'b001);
    fork
      do_op(1, 32'h44, 32'h4C, 3'b010);
      begin
        for (int n = 0; n < 20 && !bus.resp0_valid; n++) @(negedge clk);
        repeat (4) @(posedge clk);
        #1 bus.resp0_ready = 1;
      end
    join
    cycles(4);

    // Reset during EXEC, then the first tie goes to port 0.
    do_op(1, 32'd8, 32'd8, 3'b000);
    rst_n = 0; cycles(1); rst_n = 1;
    gnt_q = '{1'b0, 1'b1};
    exp_q.push_back({1'b0, 32'd11}); exp_q.push_back({1'b0, 32'd22});
    fork
      do_op(0, 32'd5, 32'd6, 3'b000);
      do_op(1, 32'd10, 32'd12, 3'b000);
    join
    cycles(4);

    // Reset during RESP (response held off so it is pending).
    bus.resp1_ready = 0;
    do_op(1, 32'd2, 32'd9, 3'b011);
    cycles(1);
    rst_n = 0; cycles(1); rst_n = 1;
    bus.resp1_ready = 1;
    gnt_q = '{1'b0, 1'b1};
    exp_q.push_back({1'b0, 32'd1}); exp_q.push_back({1'b0, 32'd0});
    fork
      do_op(0, 32'd1, 32'd2, 3'b101);
      do_op(1, 32'd2, 32'd1, 3'b101);
    join
    cycles(4);

    // Single requester, back-to-back.
    gnt_q = '{1'b1, 1'b1, 1'b1};
    exp_q.push_back({1'b1, 32'd2});
    exp_q.push_back({1'b0, 32'h30});
    exp_q.push_back({1'b0, 32'hFF});
    do_op(1, 32'd1, 32'd1, 3'b000);
    do_op(1, 32'hF0, 32'h3C, 3'b010);
    do_op(1, 32'hF0, 32'h0F, 3'b011);
    cycles(4);

    // Random traffic on both ports with random response backpressure.
    d0 = 0; d1 = 0;
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          logic [31:0] a;
          a = $urandom;
          do_op(0, a, ($urandom_range(0, 3) == 0) ? a : $urandom, 3'($urandom_range(0, 7)));
          repeat ($urandom_range(0, 3)) @(posedge clk);
          #1;
        end
        d0 = 1;
      end
      begin
        for (int i = 0; i < 30; i++) begin
          logic [31:0] a;
          a = $urandom;
          do_op(1, a, ($urandom_range(0, 3) == 0) ? a : $urandom, 3'($urandom_range(0, 7)));
          repeat ($urandom_range(0, 3)) @(posedge clk);
          #1;
        end
        d1 = 1;
      end
      begin
        while (!(d0 && d1)) begin
          @(posedge clk); #1;
          bus.resp0_ready = ($urandom_range(0, 3) != 0);
          bus.resp1_ready = ($urandom_range(0, 3) != 0);
        end
        bus.resp0_ready = 1;
        bus.resp1_ready = 1;
      end
    join
    cycles(6);

    chk("literal_queue_drained", 33'(exp_q.size()), 33'd0);
    chk("grant_queue_drained",   33'(gnt_q.size()), 33'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, expected finish before 2ms");
    $fatal(1, "watchdog expired");
  end

endmodule
